// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - word-organised APB memory target with byte selects, wait states and range error
module apb_mem_slave #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int SW    = DW / 8,
  parameter int DEPTH = 256,
  parameter int WS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          apb_penable,
  input  logic          apb_pwrite,
  input  logic          apb_pstrb,
  input  logic [AW-1:0] apb_paddr,
  input  logic [SW-1:0] apb_psel,
  input  logic [DW-1:0] apb_pwdata,
  output logic [DW-1:0] apb_prdata,
  output logic          apb_pready,
  output logic          apb_pslverr
);

  localparam int LB = (SW > 1) ? $clog2(SW) : 0;
  localparam int IW = AW - LB;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0] DEPTH_W = (IW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] prdata_q, prdata_d;
  logic          oor_q, oor_d;
  logic [DW-1:0] mem [DEPTH];

  logic          req, oor, enter_ack, commit;
  logic [IW-1:0] idx;
  logic [MW-1:0] midx;

  assign req  = apb_penable & apb_pstrb;
  assign idx  = apb_paddr[AW-1:LB];
  assign oor  = {1'b0, idx} >= DEPTH_W;
  assign midx = idx[MW-1:0];

  if (LB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^apb_paddr[LB-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prdata_d  = prdata_q;
    oor_d     = oor_q;
    enter_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WS > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WS - 1);
          end else begin
            enter_ack = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!req)            state_d = S_IDLE;
        else if (cnt_q == 0) enter_ack = 1'b1;
        else                 cnt_d = cnt_q - 4'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Range check and read data are captured once, as the transfer is acknowledged
    if (enter_ack) begin
      state_d  = S_ACK;
      oor_d    = oor;
      prdata_d = oor ? '0 : mem[midx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      prdata_q <= '0;
      oor_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
      oor_q    <= oor_d;
    end
  end

  assign commit = !rst && (state_q == S_ACK) && req && apb_pwrite && !oor_q;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < SW; i++) begin
        if (apb_psel[i]) mem[midx][8*i +: 8] <= apb_pwdata[8*i +: 8];
      end
    end
  end

  assign apb_prdata  = prdata_q;
  assign apb_pready  = (state_q == S_ACK) && req;
  assign apb_pslverr = apb_pready && oor_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - scoreboard bench over four slaves with WS = 0..3
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        penable = 1'b0, pwrite = 1'b0, pstrb = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  psel = '0;
  int          sel = 0;

  logic [31:0] prdata_w [4];
  logic [3:0]  pready_w, pslverr_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    apb_mem_slave #(.WS(g)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .apb_penable (penable && (sel == g)),
      .apb_pwrite  (pwrite),
      .apb_pstrb   (pstrb),
      .apb_paddr   (paddr),
      .apb_psel    (psel),
      .apb_pwdata  (pwdata),
      .apb_prdata  (prdata_w[g]),
      .apb_pready  (pready_w[g]),
      .apb_pslverr (pslverr_w[g])
    );
  end

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mdl [4][256];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic wr, input logic [31:0] addr,
                          input logic [3:0] ps, input logic [31:0] wd);
    exp_t        e;
    logic [29:0] wi;
    wi    = addr[31:2];
    e.rd  = !wr;
    e.err = (wi >= 30'd256);
    e.data = e.err ? 32'h0 : mdl[k][wi[7:0]];
    if (wr && !e.err)
      for (int b = 0; b < 4; b++)
        if (ps[b]) mdl[k][wi[7:0]][8*b +: 8] = wd[8*b +: 8];
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input string tag, input int k);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, "_sbq_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    check({tag, "_err"}, 32'(pslverr_w[k]), 32'(e.err));
    if (e.rd) check({tag, "_rdata"}, prdata_w[k], e.data);
  endtask

  // Called right after a rising edge; returns right after a rising edge with req dropped
  task automatic xfer(input string tag, input int k, input logic wr, input logic [31:0] addr,
                      input logic [3:0] ps, input logic [31:0] wd);
    bit done;
    done = 1'b0;
    push_exp(k, wr, addr, ps, wd);
    sel = k; pwrite = wr; paddr = addr; psel = ps; pwdata = wd;
    penable = 1'b1; pstrb = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (pready_w[k]) begin
        check({tag, "_lat"}, 32'(c), 32'(k + 1));
        pop_cmp(tag, k);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    penable = 1'b0; pstrb = 1'b0;
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int          n;
    int          exp_cyc [3];
    logic [31:0] b2b_addr [3];
    exp_cyc  = '{1, 3, 5};
    b2b_addr = '{32'h0, 32'h4, 32'h8};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_prdata", prdata_w[k], 32'h0);
      check("rst_pready", 32'(pready_w[k]), 32'd0);
      check("rst_pslverr", 32'(pslverr_w[k]), 32'd0);
    end
    @(posedge clk); #1;

    // Basic write/read, WS=1
    xfer("wr10", 1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    xfer("rd10", 1, 1'b0, 32'h10, 4'hF, 32'h0);

    // Byte lanes and the zero-select no-op write
    xfer("wr20a", 1, 1'b1, 32'h20, 4'hF, 32'h11223344);
    xfer("wr20b", 1, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD);
    xfer("rd20", 1, 1'b0, 32'h20, 4'h0, 32'h0);
    check("lane_const", mdl[1][8], 32'h11BB33DD);
    xfer("wr20c", 1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
    xfer("rd20c", 1, 1'b0, 32'h20, 4'hF, 32'h0);

    // Out of range: index 256 would alias word 0 if not rejected
    xfer("wr0", 1, 1'b1, 32'h0, 4'hF, 32'h0BADF00D);
    xfer("wr400", 1, 1'b1, 32'h400, 4'hF, 32'h12345678);
    xfer("rd400", 1, 1'b0, 32'h400, 4'hF, 32'h0);
    xfer("rd0", 1, 1'b0, 32'h0, 4'hF, 32'h0);
    xfer("rdtop", 1, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0);

    // Abort during wait states, WS=3
    xfer("wr30", 3, 1'b1, 32'h30, 4'hF, 32'hCAFE0001);
    sel = 3; pwrite = 1'b1; paddr = 32'h30; psel = 4'hF; pwdata = 32'h55555555;
    penable = 1'b1; pstrb = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("abort_pready", 32'(pready_w[3]), 32'd0);
      @(posedge clk); #1;
    end
    penable = 1'b0; pstrb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_idle", 32'(pready_w[3]), 32'd0);
      @(posedge clk); #1;
    end
    xfer("rd30", 3, 1'b0, 32'h30, 4'hF, 32'h0);

    // Back-to-back reads, WS=0, request held high throughout
    xfer("p0", 0, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0);
    xfer("p4", 0, 1'b1, 32'h4, 4'hF, 32'hB1B1B1B1);
    xfer("p8", 0, 1'b1, 32'h8, 4'hF, 32'hC2C2C2C2);
    for (int i = 0; i < 3; i++) push_exp(0, 1'b0, b2b_addr[i], 4'hF, 32'h0);
    n = 0;
    sel = 0; pwrite = 1'b0; paddr = b2b_addr[0]; penable = 1'b1; pstrb = 1'b1;
    for (int c = 0; c < 10 && n < 3; c++) begin
      @(negedge clk);
      if (pready_w[0]) begin
        check("b2b_cyc", 32'(c), 32'(exp_cyc[n]));
        pop_cmp("b2b", 0);
        n++;
        @(posedge clk); #1;
        if (n < 3) paddr = b2b_addr[n];
        else begin penable = 1'b0; pstrb = 1'b0; end
      end else begin
        @(posedge clk); #1;
      end
    end
    penable = 1'b0; pstrb = 1'b0;
    check("b2b_count", 32'(n), 32'd3);

    // Reset during wait states of a write, WS=2
    xfer("wr40", 2, 1'b1, 32'h40, 4'hF, 32'h0F0F1234);
    xfer("rd40a", 2, 1'b0, 32'h40, 4'hF, 32'h0);
    sel = 2; pwrite = 1'b1; paddr = 32'h40; psel = 4'hF; pwdata = 32'h99999999;
    penable = 1'b1; pstrb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; penable = 1'b0; pstrb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_prdata", prdata_w[2], 32'h0);
    check("mrst_pready", 32'(pready_w[2]), 32'd0);
    check("mrst_pslverr", 32'(pslverr_w[2]), 32'd0);
    @(posedge clk); #1;
    xfer("rd40b", 2, 1'b0, 32'h40, 4'hF, 32'h0);

    check("sbq_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
